// File: rtl/qsys_resp_slave.sv
// Avalon-style read responder: queues accepted reads, returns {SRC_ID, DST_ID, tag}
// after a minimum latency with response spacing, optional periodic stall.
module qsys_resp_slave #(
    parameter int unsigned WIDTH         = 32,
    parameter logic [7:0]  SRC_ID        = 8'd1,
    parameter logic [7:0]  DST_ID        = 8'd2,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned RESP_INTERVAL = 1,
    parameter int unsigned STALL_PERIOD  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [WIDTH-1:0]      writedata,
    output logic [WIDTH-1:0]      readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = WIDTH - 16;
    localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
    localparam logic [3:0] MAX_AGE    = 4'(LATENCY);
    localparam logic [3:0] GAP_RELOAD = 4'(RESP_INTERVAL - 1);

    logic [15:0]   tag_mem [DEPTH];
    logic [3:0]    age_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   occupancy;
    logic [3:0]    gap;
    logic [SW-1:0] stall_cnt;
    logic [15:0]   next_tag;
    logic          stall;
    logic          full;
    logic          push;
    logic          wr_acc;
    logic          age_ok;
    logic          pop;
    logic          unused_inputs;

    assign unused_inputs = ^{address, writedata};

    // Backpressure depends on registered state only.
    assign stall       = (STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);
    assign full        = (occupancy == (PW + 1)'(DEPTH));
    assign waitrequest = full || stall;

    // A simultaneous read+write accepts the read and drops the write.
    assign push   = read && !waitrequest;
    assign wr_acc = write && !read && !waitrequest;

    // Popping in cycle p shows readdatavalid in p+1, and the head entry was
    // written one edge after acceptance, hence the +2.
    assign age_ok = (5'(age_mem[rd_ptr]) + 5'd2) >= 5'(LATENCY);
    assign pop    = (occupancy != '0) && age_ok && (gap == 4'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= next_tag;
        end
    end

    // Every slot ages each cycle; a fresh push restarts its slot at zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                age_mem[i] <= 4'd0;
            end else if (push && (wr_ptr == PW'(i))) begin
                age_mem[i] <= 4'd0;
            end else if (age_mem[i] != MAX_AGE) begin
                age_mem[i] <= age_mem[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            next_tag  <= 16'd1;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                next_tag <= next_tag + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (PW + 1)'(1);
                2'b01:   occupancy <= occupancy - (PW + 1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Response spacing and free-running stall phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap       <= 4'd0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                gap <= GAP_RELOAD;
            end else if (gap != 4'd0) begin
                gap <= gap - 4'd1;
            end
            if ((STALL_PERIOD == 0) || (stall_cnt == STALL_LAST)) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdatavalid <= 1'b0;
            readdata      <= '0;
            rd_count      <= 16'd0;
            wr_count      <= 16'd0;
            err           <= 1'b0;
        end else begin
            readdatavalid <= pop;
            if (pop) begin
                readdata <= {SRC_ID, DST_ID, TW'(tag_mem[rd_ptr])};
            end
            if (push) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_acc) begin
                wr_count <= wr_count + 16'd1;
            end
            if (read && write && !waitrequest) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/qsys_resp_slave.md
QSYS_RESP_SLAVE -- requirements
Module: qsys_resp_slave

Interface
REQ-001 The block SHALL provide these parameters:
- WIDTH, 32: data width, at least 17.
- SRC_ID, 1: 8-bit ID of this responder, placed in response bits [WIDTH-1:WIDTH-8].
- DST_ID, 2: 8-bit ID of the requesting master, placed in bits [WIDTH-9:WIDTH-16].
- ADDR_WIDTH, 32: address width; the address is ignored.
- LATENCY, 2: minimum read latency in cycles, range 1..8.
- DEPTH, 4: outstanding-read FIFO depth, a power of 2 in the range 2..16.
- RESP_INTERVAL, 1: minimum cycles between readdatavalid pulses, range 1..15.
- STALL_PERIOD, 0: forced-stall period; 0 disables it.

REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- address, in, ADDR_WIDTH: ignored.
- read, in, 1: read request.
- write, in, 1: write request.
- writedata, in, WIDTH: ignored except for counting.
- readdata, out, WIDTH: response data.
- readdatavalid, out, 1: response strobe.
- waitrequest, out, 1: backpressure.
- rd_count, out, 16: number of accepted reads.
- wr_count, out, 16: number of accepted writes.
- err, out, 1: sticky protocol-error flag.

Function
REQ-003 A request SHALL be accepted in a cycle where (read or write) is high and waitrequest is low.
REQ-004 waitrequest SHALL be combinational from registers only: high when FIFO occupancy equals DEPTH, or when the stall counter is in its stall cycle; it SHALL NOT depend on read or write.
REQ-005 When STALL_PERIOD=N>0:
- A free-running counter SHALL count 0..N-1 and wrap.
- waitrequest SHALL be forced high in every cycle where the counter equals N-1.
REQ-006 Each accepted read SHALL push one entry {tag, age=0} into the FIFO.
- tag is a 16-bit modulo sequence number; the first read after reset gets 1, and it wraps 65535 to 0.
- For WIDTH-16 < 16 the tag SHALL be truncated; for WIDTH-16 > 16 it SHALL be zero-extended.
REQ-007 Every entry's age SHALL increment once per cycle and saturate at LATENCY.
REQ-008 The head entry SHALL be popped when both of these hold:
- its age permits readdatavalid in cycle k+LATENCY at the earliest, where k is the acceptance cycle;
- at least RESP_INTERVAL cycles have elapsed since the previous readdatavalid.
REQ-009 On a pop, in the next cycle:
- readdatavalid SHALL be high for exactly 1 cycle;
- readdata SHALL equal {SRC_ID, DST_ID, tag}.
REQ-010 When readdatavalid is low, readdata SHALL hold its last value; readdatavalid SHALL be registered.
REQ-011 With an empty FIFO, LATENCY=2 and RESP_INTERVAL=1, a read accepted in cycle k SHALL produce readdatavalid in cycle k+2.
REQ-012 Responses SHALL be returned strictly in acceptance order, with no loss and no duplication.
REQ-013 A push and a pop in the same cycle SHALL leave occupancy unchanged and both SHALL take effect.
- When the FIFO is full, waitrequest is high, so a same-cycle push cannot occur.
REQ-014 Read pointers and write pointers SHALL wrap modulo DEPTH.
REQ-015 An accepted write SHALL increment wr_count and produce no response.
REQ-016 rd_count and wr_count SHALL wrap modulo 2^16.
REQ-017 If read and write are both high while waitrequest is low:
- the read SHALL be accepted;
- the write SHALL be dropped and not counted;
- err SHALL be set and remain set until reset.
REQ-018 A read or write asserted while waitrequest is high SHALL have no effect.
- The master holds the request until it is accepted.

Reset
REQ-019 In any cycle where rst is high, at the clock edge the block SHALL:
- clear the FIFO, ages, interval counter, stall counter and tag (next tag = 1);
- clear rd_count, wr_count and err;
- drive readdatavalid=0 and readdata=0.
REQ-020 In the cycle after rst deasserts, waitrequest SHALL be 0 unless STALL_PERIOD=1.
REQ-021 A reset asserted while reads are outstanding SHALL discard them.
- No readdatavalid SHALL occur for a discarded read after reset.

Verification
REQ-022 Defaults, read held high for 3 cycles from cycle 0:
- waitrequest stays 0;
- readdatavalid is high in cycles 2, 3 and 4;
- readdata is 0x01020001, 0x01020002, 0x01020003.
REQ-023 DEPTH=4, LATENCY=8, read held high continuously:
- reads 1-4 are accepted in cycles 0-3;
- waitrequest is high from cycle 4 until the first pop;
- exactly one read is accepted per response thereafter;
- rd_count never exceeds responses by more than 4.
REQ-024 RESP_INTERVAL=3, four back-to-back reads:
- readdatavalid pulses are exactly 3 cycles apart;
- tags are 1, 2, 3, 4 in order.
REQ-025 STALL_PERIOD=4, read held high:
- waitrequest is high in cycles 3, 7, 11, ...;
- no tag is skipped.
REQ-026 read=write=1 in one cycle, then 2 writes:
- err=1;
- rd_count=1;
- wr_count=2.
REQ-027 Two reads accepted, then rst pulsed for 1 cycle before any response, then 1 read:
- the only response after reset carries tag 1.
